mem0_token_injector: RTL

- Synchronous token source directly upstream of the Mem0 C-element stage.
- Converts a clocked "inject N tokens" command into N four-phase return-to-zero handshakes on the stage's SENDIN/ACKOUT pair, with bundled data.
- Synchronises the asynchronous acknowledge internally.
- Seeds the token ring and reports completion to clocked control logic.

---
 rtl/mem0_token_injector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem0_token_injector.sv
// mem0_token_injector
// Clocked token source feeding the Mem0 C-element stage. A START command
// asks for NUM_TOKENS tokens. Each token is one four-phase return-to-zero
// handshake on SENDOUT/ACKIN, with DOUT as bundled data. The first token
// carries DATA_IN and each following token carries the previous value + 1.
// ACKIN is asynchronous to CP and is synchronised before any decision uses it.
module mem0_token_injector #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic              CP,
  input  logic              RESETN,
  input  logic              START,
  input  logic [CNT_W-1:0]  NUM_TOKENS,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              SENDOUT,
  input  logic              ACKIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  INJECTED
);

  // IDLE  : waiting for a command
  // SETUP : bundling margin; DOUT settles while SENDOUT is low
  // REQ   : SENDOUT high, waiting for the acknowledge to rise
  // RTZ   : SENDOUT low, waiting for the acknowledge to fall
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sendout_q, sendout_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    injected_q, injected_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  // Synchroniser chain for the asynchronous acknowledge.
  // Every decision uses only the last flop of the chain.
  always_ff @(posedge CP) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples values from before the edge. Blocking assignments here would
    // collapse the chain into a single flop.
    if (!RESETN) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ACKIN};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // State register and registered outputs. The reset is synchronous only.
  always_ff @(posedge CP) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      sendout_q   <= 1'b0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      injected_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      sendout_q   <= sendout_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      injected_q  <= injected_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic and next values for the registered outputs.
  always_comb begin
    // NOTE: each signal gets a default before the case statement. A signal
    // that is left unassigned on some path would otherwise infer a latch.
    state_d     = state_q;
    sendout_d   = sendout_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    injected_d  = injected_q;
    remaining_d = remaining_q;

    unique case (state_q)
      IDLE: begin
        sendout_d = 1'b0;
        if (START) begin
          injected_d = '0;
          if (NUM_TOKENS != '0) begin
            dout_d      = DATA_IN;
            remaining_d = NUM_TOKENS;
            state_d     = SETUP;
          end else begin
            // An empty command completes at once and no request is raised.
            done_d = 1'b1;
          end
        end
      end

      SETUP: begin
        // A stale acknowledge can still be high here, for example after a
        // reset in the middle of a handshake. Hold the request back until
        // the acknowledge has dropped.
        sendout_d = 1'b0;
        if (!ack_s) begin
          sendout_d = 1'b1;
          state_d   = REQ;
        end
      end

      REQ: begin
        sendout_d = 1'b1;
        if (ack_s) begin
          sendout_d = 1'b0;
          if (injected_q != '1) begin
            injected_d = injected_q + CNT_W'(1);
          end
          state_d = RTZ;
        end
      end

      RTZ: begin
        sendout_d = 1'b0;
        if (!ack_s) begin
          if (remaining_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // Change the data only once the handshake has fully returned to
            // zero, so the bundled data never moves under a live request.
            remaining_d = remaining_q - CNT_W'(1);
            dout_d      = dout_q + DATA_W'(1);
            state_d     = SETUP;
          end
        end
      end

      default: begin
        sendout_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign SENDOUT  = sendout_q;
  assign DOUT     = dout_q;
  assign DONE     = done_q;
  assign INJECTED = injected_q;
  assign BUSY     = (state_q != IDLE);

endmodule
